// File: rtl/dotmatrix_frame_loader.sv
// Bus master that writes an 8x8 frame into the dotmatrix row registers,
// skipping rows whose shadow copy already matches unless forced.
module dotmatrix_frame_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         ROWS      = 8,
  parameter int         TIMEOUT   = 16
) (
  input  logic              mclock,
  input  logic              mreset_n,
  input  logic [ROWS*8-1:0] frame_i,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              force_all,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_cs,
  output logic              bus_write,
  output logic              bus_read,
  output logic [7:0]        bus_addr,
  output logic [7:0]        bus_wdata,
  output logic [3:0]        bus_strb,
  input  logic              bus_ack
);

  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    GAP,
    FIN
  } state_t;

  state_t                 state;
  state_t                 next;
  logic [ROWS-1:0][7:0]   frame_q;
  logic [ROWS-1:0][7:0]   shadow;
  logic                   force_q;
  logic                   shadow_valid;
  logic [RW-1:0]          row;
  logic [TW-1:0]          tcnt;
  logic                   accept;
  logic                   need_wr;
  logic                   last_row;
  logic                   acked;
  logic                   tout;

  assign bus_read = 1'b0;

  always_comb begin
    next     = state;
    accept   = 1'b0;
    need_wr  = 1'b0;
    acked    = 1'b0;
    tout     = 1'b0;
    last_row = (row == RW'(ROWS - 1));
    unique case (state)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          accept = 1'b1;
          next   = CHECK;
        end
      end
      CHECK: begin
        need_wr = force_q || !shadow_valid ||
                  (frame_q[row] != shadow[row]);
        if (need_wr)       next = REQ;
        else if (last_row) next = FIN;
      end
      REQ: begin
        // ack wins over a timeout landing in the same cycle
        if (bus_ack) begin
          acked = 1'b1;
          next  = GAP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tout = 1'b1;
          next = FIN;
        end
      end
      GAP:     next = last_row ? FIN : CHECK;
      FIN:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge mclock or negedge mreset_n) begin
    if (!mreset_n) state <= IDLE;
    else           state <= next;
  end

  always_ff @(posedge mclock or negedge mreset_n) begin
    if (!mreset_n) begin
      frame_ready  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      bus_cs       <= 1'b0;
      bus_write    <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_strb     <= '0;
      frame_q      <= '0;
      shadow       <= '0;
      force_q      <= 1'b0;
      shadow_valid <= 1'b0;
      row          <= '0;
      tcnt         <= '0;
    end else begin
      frame_ready <= (next == IDLE);
      busy        <= (next != IDLE);
      done        <= (next == FIN);
      if (accept) begin
        frame_q <= frame_i;
        force_q <= force_all;
        row     <= '0;
        err     <= 1'b0;
      end
      if (state == CHECK && !need_wr && !last_row) row <= row + 1'b1;
      if (state == GAP && !last_row)               row <= row + 1'b1;
      if (need_wr) begin
        bus_cs    <= 1'b1;
        bus_write <= 1'b1;
        bus_addr  <= BASE_ADDR + 8'(row);
        bus_wdata <= frame_q[row];
        bus_strb  <= 4'b0001;
        tcnt      <= '0;
      end
      if (state == REQ && !acked && !tout) tcnt <= tcnt + 1'b1;
      if (acked || tout) begin
        bus_cs    <= 1'b0;
        bus_write <= 1'b0;
        bus_addr  <= '0;
        bus_wdata <= '0;
        bus_strb  <= '0;
      end
      if (acked) shadow[row] <= frame_q[row];
      if (tout) begin
        err          <= 1'b1;
        shadow_valid <= 1'b0;
      end
      // err is only set by a timeout in the frame now finishing
      if (state == FIN && !err) shadow_valid <= 1'b1;
    end
  end

endmodule

// File: doc/dotmatrix_frame_loader.md
Name: dotmatrix_frame_loader

Overview:
Bus master that loads a complete 8x8 frame into the dotmatrix peripheral's row registers over its CS/Write/Address/Data/STRB/ack register bus. It replaces hand-sequenced write state machines in the top level. It accepts a 64-bit frame through a valid/ready handshake and keeps a shadow copy of the last successfully written rows. Only changed rows are written, unless a full rewrite is forced.

Parameters:
BASE_ADDR, 8'h00, bus address of row 0; row r is at BASE_ADDR+r.
ROWS, 8, number of rows per frame; fixed at 8 for this peripheral.
TIMEOUT, 16, maximum cycles bus_cs is held waiting for bus_ack before the transfer is aborted.

Ports:
mclock  input  1  system clock, all logic on rising edge.
mreset_n  input  1  reset, asynchronous, active-low.
frame_i  input  64  frame; row r = frame_i[8r+7:8r].
frame_valid  input  1  frame_i valid.
frame_ready  output  1  loader can accept a frame (state IDLE).
force_all  input  1  sampled with the frame; 1 = write all rows regardless of shadow.
busy  output  1  frame in progress (state != IDLE).
done  output  1  one-cycle pulse at the end of every accepted frame, including aborted frames.
err  output  1  sticky timeout flag; cleared when the next frame is accepted.
bus_cs  output  1  to dotmatrix CS.
bus_write  output  1  to dotmatrix Write.
bus_read  output  1  to dotmatrix Read; constant 0.
bus_addr  output  8  to dotmatrix Address.
bus_wdata  output  8  to dotmatrix Data_i.
bus_strb  output  4  to dotmatrix STRB; 4'b0001 during a write, 0 otherwise.
bus_ack  input  1  from dotmatrix ack.

Behaviour:
- Reset (async, mreset_n=0):
  - State IDLE; all bus outputs 0; done=0, err=0, busy=0.
  - frame_ready=1 after reset release.
  - Shadow rows 0; shadow_valid=0.
- All outputs are registered.
- States: IDLE, CHECK, REQ, GAP, FIN.
- IDLE:
  - frame_ready=1.
  - When frame_valid&frame_ready: latch frame_i and force_all, row=0, err<=0, go to CHECK.
  - frame_i and force_all are ignored outside IDLE (sender must hold).
- CHECK (1 cycle per row):
  - If force_all_latched, or !shadow_valid, or frame row != shadow row: go to REQ, and at the same edge drive bus_cs=1, bus_write=1, bus_addr=BASE_ADDR+row, bus_wdata=row data, bus_strb=4'b0001. Clear the timeout counter.
  - Otherwise skip the row: if row==7 go to FIN, else row+1 and stay in CHECK.
- REQ:
  - Bus outputs are held stable until bus_ack is sampled 1.
  - On ack: deassert all bus outputs to 0 at that edge, update that shadow row, go to GAP.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT-1 with no ack: deassert the bus, set err=1, set shadow_valid=0, go to FIN (the rest of the frame is abandoned).
- GAP:
  - 1 idle cycle with bus_cs=0 between transfers.
  - Then go to FIN if row==7, else row+1 and go to CHECK.
- FIN:
  - Pulse done=1 for one cycle.
  - If no timeout occurred in this frame, set shadow_valid=1.
  - Return to IDLE; frame_ready rises the following cycle.
- bus_ack outside REQ is ignored.
- An ack in the same cycle as the timeout limit counts as success; ack has priority.
- Write cost per row with immediate ack: CHECK, REQ (1 cycle), GAP = 3 cycles. A skipped row costs 1 cycle.
- Reset asserted mid-transfer: bus_cs drops immediately (async) and the shadow is invalidated, so the next frame rewrites all rows.

Test Plan:
1. Reset, then frame 64'h8040201008040201 with ack returned 1 cycle after CS → 8 writes, addr 0..7 with data 01,02,04,08,10,20,40,80; CS low for ≥1 cycle between writes; one done pulse; err=0.
2. Same frame again, force_all=0 → no bus_cs activity; done pulses 9 cycles after accept (8 CHECK + FIN).
3. Same frame with only row 5 changed to 8'hFF → exactly one write, addr 05, data FF, strb 0001.
4. Same frame with force_all=1 → all 8 rows written regardless of shadow.
5. bus_ack tied 0, TIMEOUT=16 → bus_cs high 16 cycles on row 0 then low; err=1; done pulses. Next frame (identical data) rewrites all 8 rows and clears err.
6. Assert mreset_n=0 while bus_cs=1 on row 3 → all outputs 0 asynchronously. After release, frame_valid held high during busy is not accepted until frame_ready=1.
